// File: rtl/flit_packetizer.sv
// rtl/flit_packetizer.sv - buffers a raw flit stream and frames it into NoC packets
//
// Incoming flits go into a FIFO. Each packet is sent as a header (target address),
// a size flit (len + 1), the service flit, and then up to MAX_PAYLOAD payload flits
// taken from the FIFO head.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   rx_i, data_i          upstream flit valid/data, held until accepted
//   credit_o              upstream may transfer (count < FIFO_DEPTH)
//   target_i              destination router address, sampled at packet start
//   eoa_i                 end-of-injection level, flushes a partial packet
//   tx_o, data_o          downstream flit valid/data
//   credit_i              downstream ready
//   busy_o                packet in flight or FIFO not empty
//   pkt_cnt_o, flit_cnt_o packet/flit counters (only with PACKETIZER_STATS_EN)
//
// Optional feature macro: PACKETIZER_STATS_EN
module flit_packetizer #(
    parameter int          FLIT_SIZE    = 32,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          MAX_PAYLOAD  = 8,
    parameter int          IDLE_TIMEOUT = 16,
    parameter logic [31:0] SERVICE      = 32'h0000_0040
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic                 credit_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    input  logic [15:0]          target_i,
    input  logic                 eoa_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 busy_o
`ifdef PACKETIZER_STATS_EN
    ,
    output logic [31:0]          pkt_cnt_o,
    output logic [31:0]          flit_cnt_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAX_PAYLOAD + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_SIZE    = 3'd2;
    localparam logic [2:0] S_SERVICE = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;

    logic [FLIT_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [2:0]           state_q, state_d;
    logic [LW-1:0]        len_q, len_d, rem_q, rem_d;
    logic [FLIT_SIZE-1:0] hdr_q, hdr_d;
    logic                 push, pop, start;

    assign credit_o = (count_q < CW'(FIFO_DEPTH));
    assign push     = rx_i && credit_o;
    assign pop      = (state_q == S_PAYLOAD) && credit_i;
    assign tx_o     = (state_q != S_IDLE);
    assign busy_o   = (state_q != S_IDLE) || (count_q != '0);

    // A full packet's worth is ready, or a partial one must be flushed.
    assign start = (count_q >= CW'(MAX_PAYLOAD)) ||
                   ((count_q != '0) && ((idle_cnt_q == IW'(IDLE_TIMEOUT)) || eoa_i));

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);

        idle_cnt_d = idle_cnt_q;
        if (push)                                idle_cnt_d = '0;
        else if (idle_cnt_q != IW'(IDLE_TIMEOUT)) idle_cnt_d = idle_cnt_q + IW'(1);

        state_d = state_q;
        len_d   = len_q;
        rem_d   = rem_q;
        hdr_d   = hdr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HEADER;
                    len_d   = (count_q >= CW'(MAX_PAYLOAD)) ? LW'(MAX_PAYLOAD) : LW'(count_q);
                    rem_d   = len_d;
                    hdr_d   = FLIT_SIZE'(target_i);
                end
            end
            S_HEADER:  if (credit_i) state_d = S_SIZE;
            S_SIZE:    if (credit_i) state_d = S_SERVICE;
            S_SERVICE: if (credit_i) state_d = S_PAYLOAD;
            S_PAYLOAD: begin
                if (credit_i) begin
                    rem_d = rem_q - LW'(1);
                    if (rem_q == LW'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_o = '0;
        case (state_q)
            S_HEADER:  data_o = hdr_q;
            S_SIZE:    data_o = FLIT_SIZE'(len_q) + FLIT_SIZE'(1);
            S_SERVICE: data_o = FLIT_SIZE'(SERVICE);
            S_PAYLOAD: data_o = mem_q[rd_ptr_q];
            default:   data_o = '0;
        endcase
    end

    // Storage is not reset; count and pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idle_cnt_q <= '0;
            state_q    <= S_IDLE;
            len_q      <= '0;
            rem_q      <= '0;
            hdr_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idle_cnt_q <= idle_cnt_d;
            state_q    <= state_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            hdr_q      <= hdr_d;
        end
    end

`ifdef PACKETIZER_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d, flit_cnt_q, flit_cnt_d;

    always_comb begin
        flit_cnt_d = (tx_o && credit_i) ? flit_cnt_q + 32'd1 : flit_cnt_q;
        pkt_cnt_d  = (pop && (rem_q == LW'(1))) ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign flit_cnt_o = flit_cnt_q;
`endif

endmodule

// File: tb/tb_flit_packetizer.sv
// tb/tb_flit_packetizer.sv - scoreboard testbench for flit_packetizer
module tb_flit_packetizer;

    logic        clk_i    = 1'b0;
    logic        rst_ni   = 1'b0;
    logic        rx_i     = 1'b0;
    logic        credit_o;
    logic [31:0] data_i   = '0;
    logic [15:0] target_i = 16'h0102;
    logic        eoa_i    = 1'b0;
    logic        tx_o;
    logic        credit_i = 1'b1;
    logic [31:0] data_o;
    logic        busy_o;
`ifdef PACKETIZER_STATS_EN
    logic [31:0] pkt_cnt, flit_cnt;
`endif

    flit_packetizer dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rx_i     (rx_i),
        .credit_o (credit_o),
        .data_i   (data_i),
        .target_i (target_i),
        .eoa_i    (eoa_i),
        .tx_o     (tx_o),
        .credit_i (credit_i),
        .data_o   (data_o),
        .busy_o   (busy_o)
`ifdef PACKETIZER_STATS_EN
        ,
        .pkt_cnt_o  (pkt_cnt),
        .flit_cnt_o (flit_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_mis = 0;
    int          cyc   = 0;
    int          acc_cyc = 0;
    int          hdr_cyc = 0;
    int          first_acc;
    logic [31:0] exp_q [$];
    logic        tx_prev    = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] data_prev  = '0;
    logic        pushes_done;
    logic [31:0] rdata [50];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Output monitor: compares every transfer against the scoreboard and
    // checks that a stalled flit does not change.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            tx_prev    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_tx", {31'b0, tx_o}, 32'd1);
                check("stall_data", data_o, data_prev);
            end
            if (tx_o && !tx_prev) hdr_cyc = cyc;
            if (tx_o && credit_i) begin
                if (exp_q.size() == 0) check("sb_extra", 32'(exp_q.size()), 32'd1);
                else                   check("data_o", data_o, exp_q.pop_front());
            end
            stall_prev = tx_o && !credit_i;
            data_prev  = data_o;
            tx_prev    = tx_o;
        end
    end

    task automatic exp_hdr(input logic [15:0] tgt, input int len);
        exp_q.push_back({16'h0, tgt});
        exp_q.push_back(32'(len + 1));
        exp_q.push_back(32'h0000_0040);
    endtask

    task automatic push(input logic [31:0] d);
        int g = 0;
        rx_i   = 1'b1;
        data_i = d;
        @(negedge clk_i);
        while (!credit_o && g < 200) begin
            @(negedge clk_i);
            g++;
        end
        if (!credit_o) check("push_credit", {31'b0, credit_o}, 32'd1);
        @(posedge clk_i);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk_i);
            g++;
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk_i);
        #1;
        check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
        check({tag, "_tx"}, {31'b0, tx_o}, 32'd0);
    endtask

    task automatic wait_tx();
        int g = 0;
        while (!tx_o && g < 500) begin
            @(negedge clk_i);
            g++;
        end
        check("wait_tx", {31'b0, tx_o}, 32'd1);
    endtask

    initial begin
        #2;
        check("rst_tx", {31'b0, tx_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_credit", {31'b0, credit_o}, 32'd1);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Full packet, back-to-back input.
        exp_hdr(16'h0102, 8);
        for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
        for (int i = 1; i <= 8; i++) begin
            push(32'(i));
            if (i == 1) first_acc = acc_cyc;
        end
        rx_i = 1'b0;
        drain("t1");
        check("t1_latency", 32'(hdr_cyc - first_acc), 32'd8);

        // Partial packet flushed by the idle timeout.
        repeat (3) @(posedge clk_i);
        #1;
        exp_hdr(16'h0102, 3);
        for (int i = 1; i <= 3; i++) exp_q.push_back(32'(i));
        for (int i = 1; i <= 3; i++) push(32'(i));
        rx_i = 1'b0;
        first_acc = acc_cyc;
        drain("t2");
        check("t2_timeout", 32'(hdr_cyc - first_acc), 32'd17);

        // Backpressure: FIFO fills, then drains as 8, 8, 4.
        credit_i = 1'b0;
        exp_hdr(16'h0102, 8);
        for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
        exp_hdr(16'h0304, 8);
        for (int i = 9; i <= 16; i++) exp_q.push_back(32'(i));
        exp_hdr(16'h0304, 4);
        for (int i = 17; i <= 20; i++) exp_q.push_back(32'(i));
        for (int i = 1; i <= 16; i++) push(32'(i));
        check("t3_full_credit", {31'b0, credit_o}, 32'd0);
        check("t3_stalled_tx", {31'b0, tx_o}, 32'd1);
        check("t3_stalled_hdr", data_o, 32'h0000_0102);
        target_i = 16'h0304;
        credit_i = 1'b1;
        for (int i = 17; i <= 20; i++) push(32'(i));
        rx_i = 1'b0;
        drain("t3");

        // eoa flush of a two-flit packet.
        exp_hdr(16'h0304, 2);
        exp_q.push_back(32'hA1);
        exp_q.push_back(32'hA2);
        push(32'hA1);
        push(32'hA2);
        rx_i  = 1'b0;
        eoa_i = 1'b1;
        first_acc = acc_cyc;
        drain("t4");
        check("t4_eoa_latency", 32'(hdr_cyc - first_acc), 32'd1);
        repeat (5) @(posedge clk_i);
        #1;
        check("t4_eoa_empty", {31'b0, tx_o}, 32'd0);
        eoa_i = 1'b0;

        // Random downstream stalls over 50 flits.
        for (int i = 0; i < 50; i++) rdata[i] = $urandom;
        for (int p = 0; p < 6; p++) begin
            exp_hdr(16'h0304, 8);
            for (int i = 0; i < 8; i++) exp_q.push_back(rdata[p*8 + i]);
        end
        exp_hdr(16'h0304, 2);
        exp_q.push_back(rdata[48]);
        exp_q.push_back(rdata[49]);
        pushes_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 50; i++) push(rdata[i]);
                rx_i = 1'b0;
                pushes_done = 1'b1;
            end
            begin
                int g = 0;
                while (!(pushes_done && exp_q.size() == 0) && g < 5000) begin
                    @(posedge clk_i);
                    #1;
                    credit_i = 1'($urandom_range(0, 1));
                    g++;
                end
                credit_i = 1'b1;
            end
        join
        drain("t5");

        // Reset in the middle of the payload.
        exp_hdr(16'h0304, 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hB0 + 32'(i));
        for (int i = 0; i < 8; i++) push(32'hB0 + 32'(i));
        rx_i = 1'b0;
        wait_tx();
        repeat (5) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_rst_tx", {31'b0, tx_o}, 32'd0);
        check("t6_rst_busy", {31'b0, busy_o}, 32'd0);
        check("t6_rst_credit", {31'b0, credit_o}, 32'd1);
        check("t6_rst_data", data_o, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        exp_hdr(16'h0304, 3);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hC0 + 32'(i));
        for (int i = 0; i < 3; i++) push(32'hC0 + 32'(i));
        rx_i  = 1'b0;
        eoa_i = 1'b1;
        drain("t6");
        eoa_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/flit_packetizer.md
# flit_packetizer

Downstream neighbour of the task parser in the injector path. Accepts the parser's raw 32-bit flit stream (descriptors and binaries) over the tx/credit handshake and buffers it in a FIFO. Frames the buffered flits into NoC packets: header (target address), size, service, then up to MAX_PAYLOAD payload flits. Emits the packets toward the local router port with the same tx/credit handshake.

## Interface
- FLIT_SIZE, 32, flit width; must be ≥ 32.
- FIFO_DEPTH, 16, input FIFO entries; power of two, ≥ MAX_PAYLOAD.
- MAX_PAYLOAD, 8, maximum payload flits per packet; ≥ 1.
- IDLE_TIMEOUT, 16, consecutive idle input cycles before a partial packet is flushed; ≥ 1.
- SERVICE, 32'h0000_0040, constant placed in the service flit.

- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- rx_i  in  1  upstream flit valid; held with data_i until accepted.
- credit_o  out  1  upstream may transfer; equals count < FIFO_DEPTH.
- data_i  in  FLIT_SIZE  upstream flit.
- target_i  in  16  destination router address (parser mapper address); sampled at packet start.
- eoa_i  in  1  upstream end-of-injection level; forces flush of the partial packet.
- tx_o  out  1  downstream flit valid.
- credit_i  in  1  downstream ready.
- data_o  out  FLIT_SIZE  downstream flit.
- busy_o  out  1  state != IDLE or count != 0.

## Operation
- Input accept: rx_i && credit_o in a cycle pushes data_i. Output transfer: tx_o && credit_i.
- FIFO: registered count and read/write pointers that wrap modulo FIFO_DEPTH. Push and pop in the same cycle leave count unchanged. No push when count == FIFO_DEPTH, including in a same-cycle pop (credit_o is conservative). Pops occur only in PAYLOAD.
- idle_cnt counts cycles without an input accept. It is cleared on accept and saturates at IDLE_TIMEOUT.
- FSM states: IDLE, HEADER, SIZE, SERVICE, PAYLOAD.
  - IDLE → HEADER when count ≥ MAX_PAYLOAD, or count > 0 && (idle_cnt == IDLE_TIMEOUT || eoa_i). On this transition:
    - len ← min(count, MAX_PAYLOAD).
    - hdr ← zero-extended target_i.
  - HEADER → SIZE, SIZE → SERVICE, SERVICE → PAYLOAD, each on credit_i; otherwise the state holds.
  - PAYLOAD: each credit_i pops one flit and decrements remaining. The flit with remaining == 1 returns the FSM to IDLE.
- data_o by state:
  - HEADER: hdr.
  - SIZE: len + 1 (service plus payload), zero-extended.
  - SERVICE: SERVICE.
  - PAYLOAD: FIFO head.
  - IDLE: 0.
- tx_o = state != IDLE.
- len ≤ count at start, and count only grows otherwise, so PAYLOAD never underflows.
- The FIFO keeps accepting input during packet emission.

## Timing
- Reset values and reset behaviour:
  - Outputs: tx_o=0, data_o=0, credit_o=1, busy_o=0.
  - State IDLE, count/pointers/idle_cnt/len = 0.
  - Reset asserted mid-packet drops the packet and FIFO contents immediately.
- Push at cycle N becomes visible in count at N+1. The start condition evaluates at N+1, and HEADER is presented at N+2.
- Packet takes len + 3 transfer cycles with credit_i constant high.
- At least one IDLE cycle occurs between consecutive packets.
- credit_i low holds tx_o and data_o stable.
- Timeout: with the last accept at cycle N, idle_cnt reaches IDLE_TIMEOUT at N+IDLE_TIMEOUT+1 and HEADER appears one cycle later.
- eoa_i with count == 0 has no effect.
- target_i changes after packet start do not affect the current packet.

## Configuration
- PACKETIZER_STATS_EN defined:
  - Adds outputs pkt_cnt_o[31:0] and flit_cnt_o[31:0], both reset to 0 and wrapping.
  - pkt_cnt_o increments on the final PAYLOAD transfer.
  - flit_cnt_o increments on every output transfer.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Defaults, 8 flits 1..8 pushed back-to-back, credit_i=1, target_i=16'h0102 → output 0x0102, 9, 0x40, 1..8; push of the first flit at cycle N gives HEADER at N+9.
- Push 3 flits, then rx_i=0 → after 16 idle cycles the packet 0x0102, 4, 0x40, 1, 2, 3 is emitted; busy_o falls after the last flit.
- Push 20 flits with credit_i=0 → credit_o drops after 16 accepted; release credit_i → packets of 8, 8, then 4 (after timeout), data in order.
- Push 2 flits, assert eoa_i on the next cycle → immediate flush; size flit = 3.
- Toggle credit_i randomly on 50 flits → no loss or duplication, data_o stable while stalled; simultaneous push/pop at count 16 is not allowed.
- Assert rst_ni=0 during PAYLOAD → tx_o=0 and busy_o=0 asynchronously; the next packet starts clean with the correct size.
